// File: rtl/pattern_event_arbiter.sv
// pattern_event_arbiter
//   Shares one downstream event consumer between NCH pattern detectors.
//   A raised found level is granted round-robin and offered downstream with
//   a valid/ready handshake. A 4-phase ack then runs back to the granted
//   detector. The block also keeps a saturating event count, a sticky
//   overflow flag and a sticky timeout for detectors that never drop found.
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset_sync   synchronous active-high reset
//   found_in     per-channel found level from the detectors
//   det_ack      per-channel acknowledge, at most one bit set
//   evt_valid    event offered downstream
//   evt_ch       index of the offered channel
//   evt_ready    downstream accepts the event
//   evt_count    accepted events, saturating
//   overflow     sticky: a transfer happened while evt_count was at max
//   ack_timeout  sticky: a channel held found past ACK_TO ack cycles
//   busy         arbiter is not idle
module pattern_event_arbiter #(
  parameter  int NCH    = 4,
  parameter  int CNT_W  = 8,
  parameter  int ACK_TO = 16,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int TMR_W  = $clog2(ACK_TO + 1)
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic [NCH-1:0]   found_in,
  output logic [NCH-1:0]   det_ack,
  output logic             evt_valid,
  output logic [CH_W-1:0]  evt_ch,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             ack_timeout,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_ACK} state_t;

  state_t             state_q,    state_d;
  logic [CH_W-1:0]    grant_q,    grant_d;
  logic [CH_W-1:0]    rr_q,       rr_d;
  logic [NCH-1:0]     wait_low_q, wait_low_d;
  logic [TMR_W-1:0]   timer_q,    timer_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic               ovf_q,      ovf_d;
  logic               to_q,       to_d;

  logic [NCH-1:0]     req;
  logic               any_req;
  logic [CH_W-1:0]    pick;
  logic [CH_W-1:0]    rr_after;

  // A channel that timed out stays masked until it has dropped found once.
  assign req = found_in & ~wait_low_q;

  // Round-robin pick: scan offsets from the highest down so the smallest
  // offset from rr_q is the one left standing.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] sel;
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    sel     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      sel = idx[CH_W-1:0];
      if (req[sel]) begin
        any_req = 1'b1;
        pick    = sel;
      end
    end
  end

  assign rr_after = (grant_q == CH_W'(NCH - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    timer_d    = timer_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    to_d       = to_q;
    wait_low_d = wait_low_q & found_in;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        // The offer is held regardless of found_in until downstream takes it.
        if (evt_ready) begin
          state_d = S_ACK;
          timer_d = '0;
          if (count_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
          else                          count_d = count_q + 1'b1;
        end
      end
      S_ACK: begin
        if (!found_in[grant_q]) begin
          state_d = S_IDLE;
          rr_d    = rr_after;
        end else if (timer_q == TMR_W'(ACK_TO - 1)) begin
          state_d             = S_IDLE;
          rr_d                = rr_after;
          to_d                = 1'b1;
          wait_low_d[grant_q] = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      wait_low_q <= '0;
      timer_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      wait_low_q <= wait_low_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      to_q       <= to_d;
    end
  end

  assign evt_valid   = (state_q == S_OFFER);
  assign evt_ch      = evt_valid ? grant_q : '0;
  assign busy        = (state_q != S_IDLE);
  assign evt_count   = count_q;
  assign overflow    = ovf_q;
  assign ack_timeout = to_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ack
    assign det_ack[gi] = (state_q == S_ACK) && (grant_q == CH_W'(gi));
  end

endmodule

// File: tb/tb_pattern_event_arbiter.sv
module tb_pattern_event_arbiter;

  logic       clk;
  logic       reset_sync;
  logic [3:0] found_in;
  logic [3:0] det_ack;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_ready;
  logic [1:0] evt_count;
  logic       overflow;
  logic       ack_timeout;
  logic       busy;

  int   errors = 0;
  int   checks = 0;
  int   xfers  = 0;
  int   exp_q[$];
  int   exp_count = 0;
  logic exp_ovf   = 1'b0;

  pattern_event_arbiter #(.NCH(4), .CNT_W(2), .ACK_TO(16)) dut (
    .clk         (clk),
    .reset_sync  (reset_sync),
    .found_in    (found_in),
    .det_ack     (det_ack),
    .evt_valid   (evt_valid),
    .evt_ch      (evt_ch),
    .evt_ready   (evt_ready),
    .evt_count   (evt_count),
    .overflow    (overflow),
    .ack_timeout (ack_timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  // Scoreboard side: every accepted event pops the channel the stimulus
  // expected, and a saturating count model follows the transfers.
  always @(negedge clk) begin
    if (reset_sync) begin
      exp_count = 0;
      exp_ovf   = 1'b0;
    end else if (evt_valid && evt_ready) begin
      xfers++;
      $display("xfer #%0d ch=%0d t=%0t", xfers, evt_ch, $time);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_xfer: observed ch=%0d expected none", evt_ch);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("xfer_ch", evt_ch, e);
      end
      if (exp_count == 3) exp_ovf = 1'b1;
      else                exp_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int cnt;
    reset_sync = 1'b1;
    found_in   = '0;
    evt_ready  = 1'b0;
    tick();
    tick();
    reset_sync = 1'b0;
    check("rst_ack",   det_ack,     0);
    check("rst_valid", evt_valid,   0);
    check("rst_ch",    evt_ch,      0);
    check("rst_count", evt_count,   0);
    check("rst_ovf",   overflow,    0);
    check("rst_to",    ack_timeout, 0);
    check("rst_busy",  busy,        0);

    // Single channel
    evt_ready = 1'b1;
    found_in  = 4'b0100;
    exp_q.push_back(2);
    tick();
    check("t1_valid", evt_valid, 1);
    check("t1_ch",    evt_ch,    2);
    check("t1_noack", det_ack,   0);
    tick();
    check("t1_ack",    det_ack,   4'b0100);
    check("t1_vdrop",  evt_valid, 0);
    tick();
    check("t1_ackhold", det_ack, 4'b0100);
    found_in = 4'b0000;
    tick();
    check("t1_ackclr", det_ack,   0);
    check("t1_busy",   busy,      0);
    check("t1_count",  evt_count, 1);

    reset_sync = 1'b1;
    tick();
    reset_sync = 1'b0;
    check("rst2_count", evt_count, 0);

    // Round-robin with all channels requesting; also drives saturation
    found_in = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    base = xfers;
    n    = 0;
    while (xfers < base + 5 && n < 200) begin
      tick();
      n++;
      check("rr_onehot", ($countones(det_ack) <= 1), 1);
      if (xfers == base + 3) check("sat_ovf_pre", overflow, 0);
      for (int i = 0; i < 4; i++) begin
        if (det_ack[i])       found_in[i] = 1'b0;
        else if (!found_in[i]) found_in[i] = 1'b1;
      end
    end
    check("rr_xfers", xfers - base, 5);
    found_in = 4'b0000;
    wait_idle("rr");
    check("sat_count", evt_count, 3);
    check("sat_ovf",   overflow,  1);
    check("sat_model_cnt", evt_count, exp_count);
    check("sat_model_ovf", overflow,  exp_ovf);
    check("rr_queue", exp_q.size(), 0);

    // Backpressure
    evt_ready = 1'b0;
    found_in  = 4'b0010;
    exp_q.push_back(1);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", evt_valid, 1);
      check("bp_ch",    evt_ch,    1);
      if (c == 1) found_in = 4'b0000;
      tick();
    end
    check("bp_valid_end", evt_valid, 1);
    evt_ready = 1'b1;
    tick();
    check("bp_ack",   det_ack, 4'b0010);
    tick();
    check("bp_ackclr", det_ack, 0);
    check("bp_busy",   busy,    0);

    // Timeout on channel 3 with channel 0 pending
    found_in = 4'b1001;
    exp_q.push_back(3);
    exp_q.push_back(0);
    tick();
    check("to_valid", evt_valid, 1);
    check("to_ch",    evt_ch,    3);
    tick();
    check("to_ack", det_ack, 4'b1000);
    cnt = 0;
    while (det_ack == 4'b1000 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("to_len",    cnt,         16);
    check("to_flag",   ack_timeout, 1);
    check("to_ackclr", det_ack,     0);
    tick();
    check("to_next_valid", evt_valid, 1);
    check("to_next_ch",    evt_ch,    0);
    tick();
    check("to_next_ack", det_ack, 4'b0001);
    found_in[0] = 1'b0;
    tick();
    check("to_next_clr", det_ack, 0);
    repeat (4) tick();
    check("to_masked", busy, 0);
    found_in[3] = 1'b0;
    tick();
    found_in[3] = 1'b1;
    exp_q.push_back(3);
    tick();
    check("to_regrant_v",  evt_valid, 1);
    check("to_regrant_ch", evt_ch,    3);
    tick();
    check("to_regrant_ack", det_ack, 4'b1000);
    found_in = 4'b0000;
    tick();
    check("to_regrant_clr", det_ack,     0);
    check("to_sticky",      ack_timeout, 1);

    // Reset mid-ACK
    found_in = 4'b0010;
    exp_q.push_back(1);
    tick();
    check("rm_ch", evt_ch, 1);
    tick();
    check("rm_ack", det_ack, 4'b0010);
    reset_sync = 1'b1;
    tick();
    check("rm_ack0",   det_ack,     0);
    check("rm_valid0", evt_valid,   0);
    check("rm_count0", evt_count,   0);
    check("rm_ovf0",   overflow,    0);
    check("rm_to0",    ack_timeout, 0);
    check("rm_busy0",  busy,        0);
    reset_sync = 1'b0;
    found_in   = 4'b0100;
    exp_q.push_back(2);
    tick();
    check("rm_valid", evt_valid, 1);
    check("rm_ch2",   evt_ch,    2);
    tick();
    check("rm_ack2", det_ack, 4'b0100);
    found_in = 4'b0000;
    tick();
    check("rm_ackclr", det_ack,   0);
    check("rm_busy",   busy,      0);
    check("rm_count",  evt_count, 1);
    check("rm_model",  evt_count, exp_count);
    check("end_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_event_arbiter.md
Name: pattern_event_arbiter

Overview:
- Shares one downstream event consumer between NCH pattern-detector channels.
- Each detector raises a level found flag and holds it until acknowledged.
- The arbiter picks one raised channel round-robin, offers its index downstream with a valid/ready handshake, then runs a 4-phase ack back to that detector.
- Also keeps a saturating event count, a sticky overflow flag, and a timeout on detectors that never drop found.

Parameters:
- NCH, 4: number of detector channels (2..16).
- CNT_W, 8: width of evt_count.
- ACK_TO, 16: max cycles det_ack is held waiting for found_in to drop (≥2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_sync  in  1  synchronous, active-high reset.
- found_in  in  NCH  per-channel found level from detectors.
- det_ack  out  NCH  per-channel acknowledge to detectors; at most one bit set.
- evt_valid  out  1  event offered downstream.
- evt_ch  out  max(1,$clog2(NCH))  index of the offered channel.
- evt_ready  in  1  downstream accepts the event.
- evt_count  out  CNT_W  accepted events, saturating.
- overflow  out  1  sticky: a transfer occurred while evt_count was at max.
- ack_timeout  out  1  sticky: a channel held found past ACK_TO.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_sync=1 at a posedge): state=IDLE, all outputs 0, rr pointer=0, wait_low mask=0, timer=0. Reset takes effect mid-operation in any state; an in-flight offer or ack is abandoned without completing.
- Eligible request: req[i] = found_in[i] & ~wait_low[i].
- State IDLE:
  - If any req, grant the first set bit scanning from rr pointer upward with wrap.
  - Next cycle: state=OFFER, evt_valid=1, evt_ch=grant. Latency from found_in high to evt_valid is 1 cycle.
- State OFFER:
  - evt_valid and evt_ch stay stable until a transfer (evt_valid & evt_ready at a posedge). evt_valid never drops before transfer, even if found_in[grant] falls.
  - On transfer: evt_count += 1, saturating at 2^CNT_W-1. If count is already at max, set overflow instead.
  - Next cycle: state=ACK, evt_valid=0, det_ack[grant]=1, timer=0.
- State ACK:
  - det_ack[grant] is held at least 1 cycle.
  - If found_in[grant]==0 is sampled: det_ack=0 next cycle, state=IDLE, rr pointer=(grant+1) mod NCH.
  - Else timer increments. When timer reaches ACK_TO-1 with found still high: det_ack=0, ack_timeout=1, wait_low[grant]=1, rr advances, state=IDLE.
- wait_low[i] clears on any cycle where found_in[i]==0. A timed-out channel is not re-granted until it drops found and re-raises it.
- Channels raising found during OFFER or ACK stay pending; there is no queue beyond the found levels themselves.
- Fairness: with all channels continuously requesting, grants cycle 0,1,…,NCH-1,0. No channel waits more than NCH-1 other grants.
- IDLE→OFFER with no bubble: a new grant may issue on the first IDLE cycle after ACK.
- evt_count and the sticky flags clear only on reset.

Test Plan:
- Single channel: found_in=0b0100 at cycle 0, evt_ready=1, found drops 2 cycles after det_ack rises → evt_valid=1 with evt_ch=2 at cycle 1; det_ack=0b0100 at cycle 2; det_ack=0 two cycles later; evt_count=1; busy=0 after.
- Round-robin: found_in=0b1111 held, each detector drops found 1 cycle after its ack and re-raises 1 cycle later → evt_ch sequence is 0,1,2,3,0; never two det_ack bits set together.
- Backpressure: evt_ready=0 for 5 cycles after evt_valid rises, and found_in[1] drops meanwhile → evt_valid and evt_ch=1 hold stable; transfer on the first ready cycle; det_ack[1] pulses exactly 1 cycle.
- Timeout: ACK_TO=16, channel 3 never drops found → det_ack[3] high 16 cycles then 0; ack_timeout=1; channel 3 is not re-offered until found_in[3] goes low and high again; channel 0 request is served next.
- Saturation: CNT_W=2 with 5 accepted events → evt_count sticks at 3, overflow=1 after the 4th transfer.
- Reset mid-ACK: assert reset_sync during det_ack=1 → next cycle all outputs 0, evt_count=0, rr pointer=0; request on channel 2 is then granted normally.
